ctrl_alu_wb_unit: RTL and testbench
===================================

Name: ctrl_alu_wb_unit

Overview:
- Execute-stage core of the 8-bit single-cycle MIPS-style CPU: main decoder (Ctrl role), ALU operand select, 8-bit ALU with zero flag, and ALU/RAM write-back mux (Mux2to1 role).
- Decodes opcode Inst[7:5] into datapath strobes and computes the ALU result and write-back data combinationally.
- Holds one bit of state, a sticky halt flag, that freezes PC updates after the halt opcode.

Parameters:
- WIDTH, 8, data path width of operands, result and write-back data.

Ports:
- Clk  input  1  system clock; only the halt flag is clocked.
- Reset  input  1  synchronous, active-high reset.
- Opcode  input  3  instruction bits [7:5].
- Imm  input  2  instruction bits [1:0], immediate field.
- Data1  input  WIDTH  register-file read port 1, ALU operand A.
- Data2  input  WIDTH  register-file read port 2.
- RAMResult  input  WIDTH  data-memory read data.
- PCWrite  output  1  PC may update this cycle.
- Regdst  output  1  1 selects rd = Inst[1:0]; 0 selects rt = Inst[3:2].
- Jump  output  1  relative jump.
- Branch  output  1  branch-if-equal.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- MemtoReg  output  1  write-back source select.
- RegWrite  output  1  register-file write enable.
- ALUOp  output  2  ALU operation code.
- ALUSrc  output  2  ALU B-operand select.
- ALUResult  output  WIDTH  ALU result.
- Zero  output  1  1 when ALUResult == 0.
- WBData  output  WIDTH  write-back data.
- Halted  output  1  sticky halt flag.

Behaviour:
- Decode is combinational from Opcode. Signals not listed for an opcode are 0.
  - 000 add: Regdst=1, RegWrite=1, ALUOp=00, ALUSrc=00.
  - 001 sub: Regdst=1, RegWrite=1, ALUOp=01, ALUSrc=00.
  - 010 addi: RegWrite=1, ALUOp=00, ALUSrc=01.
  - 011 lw: MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=00, ALUSrc=10.
  - 100 sw: MemWrite=1, ALUOp=00, ALUSrc=10.
  - 101 beq: Branch=1, ALUOp=01, ALUSrc=00.
  - 110 j: Jump=1.
  - 111 halt: all strobes 0, PCWrite=0.
  - PCWrite=1 for every opcode except 111, and only while Halted=0.
- Gating: while Reset=1 or Halted=1, every strobe output is 0 (PCWrite, Regdst, Jump, Branch, MemRead, MemWrite, MemtoReg, RegWrite, ALUOp=00, ALUSrc=00). ALUResult and WBData still compute from inputs under the gated selects.
- Halt flag:
  - On posedge Clk with Reset=1, Halted <= 0.
  - Else, if Opcode==111, Halted <= 1.
  - Else Halted holds. Once set, it stays set until Reset.
  - Reset takes priority over a simultaneous halt opcode.
- ALU B-operand mux:
  - ALUSrc 00 -> Data2.
  - 01 -> Imm sign-extended to WIDTH (Imm[1] replicated).
  - 10 -> Imm zero-extended.
  - 11 -> Data2.
- ALU:
  - ALUOp 00: A+B.
  - 01: A-B.
  - 10: A&B.
  - 11: A|B.
  - All arithmetic is modulo 2^WIDTH; carry and borrow are discarded.
- Zero = (ALUResult == 0), combinational.
- WBData = MemtoReg ? RAMResult : ALUResult.
- Latency: all data outputs are zero-cycle combinational. Halted changes one edge after the halt opcode is presented.
- No X propagation: every case statement has a default that drives 0.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, adds outputs Negative (ALUResult[WIDTH-1]) and Overflow (signed two's-complement overflow).
  - For add: operands have the same sign and the result sign differs.
  - For sub: operands have different signs and the result sign differs from A.
  - Overflow is 0 for ALUOp 10 and 11.
- When undefined, these ports do not exist. All other behaviour is identical.

Test Plan:
- Reset=1 for one edge with Opcode=000 -> all strobes 0, Halted=0. Release Reset, Opcode=000, Data1=8'h05, Data2=8'h03 -> ALUResult=8'h08, Regdst=1, RegWrite=1, PCWrite=1, Zero=0, WBData=8'h08.
- Opcode=101, Data1=Data2=8'h2A -> ALUOp=01, ALUResult=0, Zero=1, Branch=1. Data2=8'h2B -> ALUResult=8'hFF, Zero=0.
- Opcode=010, Data1=8'h10, Imm=2'b11 -> B=8'hFF, ALUResult=8'h0F. Opcode=011, Imm=2'b11 -> B=8'h03, ALUResult=8'h13, MemRead=1, MemtoReg=1; RAMResult=8'hA5 -> WBData=8'hA5.
- Wrap-around: add 8'hFF + 8'h01 -> ALUResult=8'h00, Zero=1. With ALU_FLAGS_EN: 8'h7F + 8'h01 -> Overflow=1, Negative=1.
- Opcode=111 at an edge -> Halted=1 next cycle. Then Opcode=000 -> PCWrite=0, RegWrite=0, Halted still 1. Reset=1 at an edge -> Halted=0, and Opcode=000 gives PCWrite=1 again.
- Opcode=111 and Reset=1 at the same edge -> Halted=0 after the edge.

Source files
------------

// File: rtl/ctrl_alu_wb_unit_if.sv
// ctrl_alu_wb_unit_if: decode, ALU and write-back signal bundle.
// Negative/Overflow exist only when ALU_FLAGS_EN is defined.
interface ctrl_alu_wb_unit_if #(parameter int WIDTH = 8);
   logic [2:0]       Opcode;
   logic [1:0]       Imm;
   logic [WIDTH-1:0] Data1;
   logic [WIDTH-1:0] Data2;
   logic [WIDTH-1:0] RAMResult;
   logic             PCWrite;
   logic             Regdst;
   logic             Jump;
   logic             Branch;
   logic             MemRead;
   logic             MemWrite;
   logic             MemtoReg;
   logic             RegWrite;
   logic [1:0]       ALUOp;
   logic [1:0]       ALUSrc;
   logic [WIDTH-1:0] ALUResult;
   logic             Zero;
   logic [WIDTH-1:0] WBData;
   logic             Halted;
`ifdef ALU_FLAGS_EN
   logic             Negative;
   logic             Overflow;
   modport master (output Opcode, Imm, Data1, Data2, RAMResult,
                   input PCWrite, Regdst, Jump, Branch, MemRead, MemWrite, MemtoReg, RegWrite,
                   ALUOp, ALUSrc, ALUResult, Zero, WBData, Halted, Negative, Overflow);
   modport slave (input Opcode, Imm, Data1, Data2, RAMResult,
                  output PCWrite, Regdst, Jump, Branch, MemRead, MemWrite, MemtoReg, RegWrite,
                  ALUOp, ALUSrc, ALUResult, Zero, WBData, Halted, Negative, Overflow);
`else
   modport master (output Opcode, Imm, Data1, Data2, RAMResult,
                   input PCWrite, Regdst, Jump, Branch, MemRead, MemWrite, MemtoReg, RegWrite,
                   ALUOp, ALUSrc, ALUResult, Zero, WBData, Halted);
   modport slave (input Opcode, Imm, Data1, Data2, RAMResult,
                  output PCWrite, Regdst, Jump, Branch, MemRead, MemWrite, MemtoReg, RegWrite,
                  ALUOp, ALUSrc, ALUResult, Zero, WBData, Halted);
`endif
endinterface

// File: rtl/ctrl_alu_wb_unit.sv
// ctrl_alu_wb_unit: main decoder, ALU with operand select, write-back mux and sticky halt.
// Optional ALU_FLAGS_EN adds Negative/Overflow outputs.
module ctrl_alu_wb_unit #(parameter int WIDTH = 8) (
   input logic Clk,
   input logic Reset,
   ctrl_alu_wb_unit_if.slave bus
);
   logic             halted;
   logic             active;
   logic [11:0]      dec;
   logic [11:0]      strb;
   logic [1:0]       alu_op;
   logic [1:0]       alu_src;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] alu_result;
   // dec = {PCWrite, Regdst, Jump, Branch, MemRead, MemWrite, MemtoReg, RegWrite, ALUOp, ALUSrc}
   always_comb begin
      case (bus.Opcode)
         3'b000:  dec = 12'b1100_0001_0000;
         3'b001:  dec = 12'b1100_0001_0100;
         3'b010:  dec = 12'b1000_0001_0001;
         3'b011:  dec = 12'b1000_1011_0010;
         3'b100:  dec = 12'b1000_0100_0010;
         3'b101:  dec = 12'b1001_0000_0100;
         3'b110:  dec = 12'b1010_0000_0000;
         default: dec = '0;
      endcase
   end
   assign active  = !Reset && !halted;
   assign strb    = active ? dec : '0;
   assign alu_op  = strb[3:2];
   assign alu_src = strb[1:0];
   assign {bus.PCWrite, bus.Regdst, bus.Jump, bus.Branch, bus.MemRead, bus.MemWrite,
           bus.MemtoReg, bus.RegWrite, bus.ALUOp, bus.ALUSrc} = strb;
   always_comb begin
      case (alu_src)
         2'b00, 2'b11: b = bus.Data2;
         2'b01:        b = {{(WIDTH-2){bus.Imm[1]}}, bus.Imm};
         2'b10:        b = {{(WIDTH-2){1'b0}}, bus.Imm};
         default:      b = '0;
      endcase
   end
   always_comb begin
      case (alu_op)
         2'b00:   alu_result = bus.Data1 + b;
         2'b01:   alu_result = bus.Data1 - b;
         2'b10:   alu_result = bus.Data1 & b;
         2'b11:   alu_result = bus.Data1 | b;
         default: alu_result = '0;
      endcase
   end
   assign bus.ALUResult = alu_result;
   assign bus.Zero      = (alu_result == '0);
   assign bus.WBData    = strb[5] ? bus.RAMResult : alu_result;
   assign bus.Halted    = halted;
`ifdef ALU_FLAGS_EN
   assign bus.Negative = alu_result[WIDTH-1];
   assign bus.Overflow = (alu_op == 2'b00) ? (bus.Data1[WIDTH-1] == b[WIDTH-1]) && (alu_result[WIDTH-1] != bus.Data1[WIDTH-1])
                       : (alu_op == 2'b01) ? (bus.Data1[WIDTH-1] != b[WIDTH-1]) && (alu_result[WIDTH-1] != bus.Data1[WIDTH-1])
                       : 1'b0;
`endif
   always_ff @(posedge Clk) begin
      if (Reset) halted <= 1'b0;
      else if (bus.Opcode == 3'b111) halted <= 1'b1;
   end
endmodule

// File: tb/tb_ctrl_alu_wb_unit.sv
// tb_ctrl_alu_wb_unit: directed and randomized checks of ctrl_alu_wb_unit against an arithmetic model.
module tb_ctrl_alu_wb_unit;
   logic       Clk = 1'b0;
   logic       Reset;
   int         checks = 0;
   int         errors = 0;
   bit         mh = 1'b0;
   logic [2:0] op;
   logic [1:0] imm;
   logic [7:0] d1, d2, ram;
   logic       rst;

   ctrl_alu_wb_unit_if #(.WIDTH(8)) bus();
   ctrl_alu_wb_unit #(.WIDTH(8)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [11:0] strb;
      logic [7:0]  res;
      logic        z;
      logic [7:0]  wb;
      logic        halted;
`ifdef ALU_FLAGS_EN
      logic        neg;
      logic        ovf;
`endif
   } view_t;

   function automatic view_t model();
      view_t v;
      logic [11:0] t [8];
      int a, bv, r, sa, sb, s;
      t[0] = 12'b1_1_0_0_0_0_0_1_00_00;
      t[1] = 12'b1_1_0_0_0_0_0_1_01_00;
      t[2] = 12'b1_0_0_0_0_0_0_1_00_01;
      t[3] = 12'b1_0_0_0_1_0_1_1_00_10;
      t[4] = 12'b1_0_0_0_0_1_0_0_00_10;
      t[5] = 12'b1_0_0_1_0_0_0_0_01_00;
      t[6] = 12'b1_0_1_0_0_0_0_0_00_00;
      t[7] = 12'b0;
      v.strb = (rst || mh) ? 12'b0 : t[op];
      a = int'(d1);
      case (v.strb[1:0])
         2'd1:    bv = imm[1] ? int'(imm) - 4 : int'(imm);
         2'd2:    bv = int'(imm);
         default: bv = int'(d2);
      endcase
      case (v.strb[3:2])
         2'd0:    r = (a + bv) & 255;
         2'd1:    r = (a - bv) & 255;
         2'd2:    r = (a & bv) & 255;
         default: r = (a | bv) & 255;
      endcase
      v.res = r[7:0];
      v.z = (r == 0);
      v.wb = v.strb[5] ? ram : r[7:0];
      v.halted = mh;
      sa = a > 127 ? a - 256 : a;
      sb = (bv & 255) > 127 ? (bv & 255) - 256 : (bv & 255);
      s = (v.strb[3:2] == 2'd0) ? sa + sb : sa - sb;
`ifdef ALU_FLAGS_EN
      v.neg = r > 127;
      v.ovf = (v.strb[3:2] < 2'd2) && (s > 127 || s < -128);
`endif
      return v;
   endfunction

   function automatic view_t observe();
      view_t v;
      v.strb = {bus.PCWrite, bus.Regdst, bus.Jump, bus.Branch, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.RegWrite, bus.ALUOp, bus.ALUSrc};
      v.res = bus.ALUResult;
      v.z = bus.Zero;
      v.wb = bus.WBData;
      v.halted = bus.Halted;
`ifdef ALU_FLAGS_EN
      v.neg = bus.Negative;
      v.ovf = bus.Overflow;
`endif
      return v;
   endfunction

   task automatic drive(input logic [2:0] o, input logic [1:0] i, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] m, input logic r);
      op = o; imm = i; d1 = a; d2 = b; ram = m; rst = r;
      bus.Opcode = o; bus.Imm = i; bus.Data1 = a; bus.Data2 = b; bus.RAMResult = m; Reset = r;
      #1;
   endtask

   task automatic tick();
      @(posedge Clk);
      if (rst) mh = 1'b0;
      else if (op == 3'd7) mh = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_reset();
      drive(3'd0, 2'd0, 8'h05, 8'h03, 8'h00, 1'b1);
      checks++;
      if (observe().strb !== 12'b0) begin
         errors++; $display("FAIL reset_strobes: got %h want 000", observe().strb);
      end
      tick();
      checks++;
      if (observe() !== model()) begin
         errors++; $display("FAIL reset_state: got %h want %h", observe(), model());
      end
      checks++;
      if (bus.Halted !== 1'b0) begin
         errors++; $display("FAIL reset_halted: got %b want 0", bus.Halted);
      end
   endtask

   task automatic test_plan_vectors();
      drive(3'd0, 2'd0, 8'h05, 8'h03, 8'h00, 1'b0);
      checks++;
      if (observe() !== model()) begin errors++; $display("FAIL add_model: got %h want %h", observe(), model()); end
      checks++;
      if (bus.ALUResult !== 8'h08 || bus.WBData !== 8'h08 || bus.PCWrite !== 1'b1 || bus.Regdst !== 1'b1) begin
         errors++; $display("FAIL add_const: res %h wb %h pcw %b rd %b want 08 08 1 1", bus.ALUResult, bus.WBData, bus.PCWrite, bus.Regdst);
      end
      drive(3'd5, 2'd0, 8'h2A, 8'h2A, 8'h00, 1'b0);
      checks++;
      if (observe() !== model()) begin errors++; $display("FAIL beq_eq_model: got %h want %h", observe(), model()); end
      checks++;
      if (bus.Zero !== 1'b1 || bus.Branch !== 1'b1 || bus.ALUOp !== 2'b01) begin
         errors++; $display("FAIL beq_eq_const: zero %b br %b op %b want 1 1 01", bus.Zero, bus.Branch, bus.ALUOp);
      end
      drive(3'd5, 2'd0, 8'h2A, 8'h2B, 8'h00, 1'b0);
      checks++;
      if (bus.ALUResult !== 8'hFF || bus.Zero !== 1'b0) begin
         errors++; $display("FAIL beq_ne: res %h zero %b want ff 0", bus.ALUResult, bus.Zero);
      end
      drive(3'd2, 2'b11, 8'h10, 8'h77, 8'h00, 1'b0);
      checks++;
      if (bus.ALUResult !== 8'h0F || observe() !== model()) begin
         errors++; $display("FAIL addi_sext: got %h want %h", observe(), model());
      end
      drive(3'd3, 2'b11, 8'h10, 8'h77, 8'hA5, 1'b0);
      checks++;
      if (bus.ALUResult !== 8'h13 || bus.WBData !== 8'hA5 || bus.MemRead !== 1'b1 || bus.MemtoReg !== 1'b1) begin
         errors++; $display("FAIL lw_zext: res %h wb %h mr %b m2r %b want 13 a5 1 1", bus.ALUResult, bus.WBData, bus.MemRead, bus.MemtoReg);
      end
      drive(3'd0, 2'd0, 8'hFF, 8'h01, 8'h00, 1'b0);
      checks++;
      if (bus.ALUResult !== 8'h00 || bus.Zero !== 1'b1) begin
         errors++; $display("FAIL add_wrap: res %h zero %b want 00 1", bus.ALUResult, bus.Zero);
      end
`ifdef ALU_FLAGS_EN
      drive(3'd0, 2'd0, 8'h7F, 8'h01, 8'h00, 1'b0);
      checks++;
      if (bus.Overflow !== 1'b1 || bus.Negative !== 1'b1) begin
         errors++; $display("FAIL add_ovf: ovf %b neg %b want 1 1", bus.Overflow, bus.Negative);
      end
`endif
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         drive(3'($urandom_range(0, 7)), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(0, 7) == 0);
         checks++;
         if (observe() !== model()) begin
            errors++; $display("FAIL random_pre[%0d]: got %h want %h", n, observe(), model());
         end
         tick();
         checks++;
         if (observe() !== model()) begin
            errors++; $display("FAIL random_post[%0d]: got %h want %h", n, observe(), model());
         end
      end
   endtask

   task automatic test_halt();
      drive(3'd0, 2'd0, 8'h01, 8'h02, 8'h00, 1'b1);
      tick();
      drive(3'd7, 2'd0, 8'h01, 8'h02, 8'h00, 1'b0);
      checks++;
      if (observe() !== model() || bus.PCWrite !== 1'b0 || bus.Halted !== 1'b0) begin
         errors++; $display("FAIL halt_opcode: got %h want %h", observe(), model());
      end
      tick();
      checks++;
      if (bus.Halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", bus.Halted); end
      for (int n = 0; n < 4; n++) begin
         drive(3'($urandom_range(0, 6)), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
         checks++;
         if (observe() !== model() || bus.PCWrite !== 1'b0 || bus.RegWrite !== 1'b0) begin
            errors++; $display("FAIL halt_gated[%0d]: got %h want %h", n, observe(), model());
         end
         tick();
         checks++;
         if (bus.Halted !== 1'b1) begin errors++; $display("FAIL halt_sticky[%0d]: got %b want 1", n, bus.Halted); end
      end
      drive(3'd0, 2'd0, 8'h01, 8'h02, 8'h00, 1'b1);
      tick();
      drive(3'd0, 2'd0, 8'h01, 8'h02, 8'h00, 1'b0);
      checks++;
      if (bus.Halted !== 1'b0 || bus.PCWrite !== 1'b1 || bus.ALUResult !== 8'h03) begin
         errors++; $display("FAIL halt_clear: halted %b pcw %b res %h want 0 1 03", bus.Halted, bus.PCWrite, bus.ALUResult);
      end
   endtask

   task automatic test_reset_priority();
      drive(3'd7, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1);
      tick();
      drive(3'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
      checks++;
      if (bus.Halted !== 1'b0 || bus.PCWrite !== 1'b1) begin
         errors++; $display("FAIL reset_priority: halted %b pcw %b want 0 1", bus.Halted, bus.PCWrite);
      end
   endtask

   initial begin
      test_reset();
      test_plan_vectors();
      test_halt();
      test_reset_priority();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
